// File: rtl/mcparc_core_muldiv_pkg.sv
// Shared definitions for the iterative PARC multiply/divide unit: op codes, FSM states, width.
// Optional feature macro used by the unit: MCPARC_MULDIV_EARLY_EXIT_EN.
package mcparc_core_muldiv_pkg;

    localparam int MULDIV_NBITS = 32;

    localparam logic [2:0] MULDIV_FN_MUL  = 3'd0;
    localparam logic [2:0] MULDIV_FN_DIV  = 3'd1;
    localparam logic [2:0] MULDIV_FN_DIVU = 3'd2;
    localparam logic [2:0] MULDIV_FN_REM  = 3'd3;
    localparam logic [2:0] MULDIV_FN_REMU = 3'd4;

    localparam logic [MULDIV_NBITS-1:0] MULDIV_DIVZ_QUOT = '1;

    typedef enum logic [1:0] {
        MULDIV_ST_IDLE = 2'd0,
        MULDIV_ST_CALC = 2'd1,
        MULDIV_ST_FIX  = 2'd2,
        MULDIV_ST_DONE = 2'd3
    } muldiv_state_e;

    // Only DIV and REM work on magnitudes with a sign fix-up afterwards.
    function automatic logic muldiv_fn_signed(input logic [2:0] fn);
        return (fn == MULDIV_FN_DIV) || (fn == MULDIV_FN_REM);
    endfunction

endpackage

// File: rtl/mcparc_core_muldiv_iter_dpath.sv
// Operand, shift/accumulate and remainder/quotient registers plus the final sign fix-up.
// Latency: one iteration per step pulse, result register updated on the fix pulse.
// Backpressure: none here; the FSM in the parent gates load/step/fix. Macro: MCPARC_MULDIV_EARLY_EXIT_EN.
module mcparc_core_muldiv_iter_dpath
    import mcparc_core_muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [2:0]  fn,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        step,
    input  logic        fix,
    output logic        early_done,
    output logic [31:0] result
);

    logic [2:0]  fn_r;
    logic        sign_a;
    logic        sign_b;
    logic        b_zero;
    logic [31:0] opnd;
    logic [31:0] rq_hi;
    logic [31:0] rq_lo;

    logic        signed_op;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] rem_shift;
    logic [32:0] trial;
    logic [31:0] fix_val;

    assign signed_op = muldiv_fn_signed(fn);
    assign a_mag     = (signed_op && a[31]) ? -a : a;
    assign b_mag     = (signed_op && b[31]) ? -b : b;

    // The remainder can reach 33 bits after the shift, so the trial subtract is 33 bits wide.
    assign rem_shift = {rq_hi, rq_lo[31]};
    assign trial     = rem_shift - {1'b0, opnd};

`ifdef MCPARC_MULDIV_EARLY_EXIT_EN
    assign early_done = (fn_r == MULDIV_FN_MUL) && (rq_lo == '0);
`else
    assign early_done = 1'b0;
`endif

    always_comb begin
        fix_val = '0;
        case (fn_r)
            MULDIV_FN_MUL:                 fix_val = rq_hi;
            MULDIV_FN_DIV, MULDIV_FN_DIVU: fix_val = b_zero ? MULDIV_DIVZ_QUOT
                                                   : ((sign_a ^ sign_b) ? -rq_lo : rq_lo);
            // With a zero divisor the remainder register ends up holding |a|, so this restores a.
            MULDIV_FN_REM, MULDIV_FN_REMU: fix_val = sign_a ? -rq_hi : rq_hi;
            default:                       fix_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fn_r   <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            b_zero <= 1'b0;
            opnd   <= '0;
            rq_hi  <= '0;
            rq_lo  <= '0;
            result <= '0;
        end else begin
            if (load) begin
                fn_r   <= fn;
                sign_a <= signed_op & a[31];
                sign_b <= signed_op & b[31];
                b_zero <= (b == '0);
                rq_hi  <= '0;
                if (fn == MULDIV_FN_MUL) begin
                    opnd  <= a;
                    rq_lo <= b;
                end else begin
                    opnd  <= b_mag;
                    rq_lo <= a_mag;
                end
            end else if (step) begin
                if (fn_r == MULDIV_FN_MUL) begin
                    rq_hi <= rq_hi + (rq_lo[0] ? opnd : 32'd0);
                    opnd  <= {opnd[30:0], 1'b0};
                    rq_lo <= {1'b0, rq_lo[31:1]};
                end else if (!trial[32]) begin
                    rq_hi <= trial[31:0];
                    rq_lo <= {rq_lo[30:0], 1'b1};
                end else begin
                    rq_hi <= rem_shift[31:0];
                    rq_lo <= {rq_lo[30:0], 1'b0};
                end
            end
            if (fix) begin
                result <= fix_val;
            end
        end
    end

endmodule

// File: rtl/mcparc_core_muldiv_iter.sv
// Iterative 32-bit MUL/DIV/DIVU/REM/REMU unit for the PARC execute stage; FSM and counter live here.
// Latency: 34 edges accept->resp_val (MUL shorter with MCPARC_MULDIV_EARLY_EXIT_EN defined).
// Backpressure: req_rdy only in IDLE; the result is held in DONE until resp_rdy.
module mcparc_core_muldiv_iter
    import mcparc_core_muldiv_pkg::*;
#(
    parameter int NBITS = MULDIV_NBITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_val,
    output logic             req_rdy,
    input  logic [2:0]       req_fn,
    input  logic [NBITS-1:0] req_a,
    input  logic [NBITS-1:0] req_b,
    output logic             resp_val,
    input  logic             resp_rdy,
    output logic [NBITS-1:0] resp_result
);

    muldiv_state_e state;
    logic [4:0]    cnt;
    logic          iter_done;
    logic          early_done;
    logic          load;
    logic          step;
    logic          fix;
    logic          calc_exit;

    assign load      = (state == MULDIV_ST_IDLE) && req_val && req_rdy;
    // A terminal CALC cycle after the last iteration lets the counted and early-exit paths share one exit test.
    assign calc_exit = iter_done || early_done;
    assign step      = (state == MULDIV_ST_CALC) && !calc_exit;
    assign fix       = (state == MULDIV_ST_FIX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= MULDIV_ST_IDLE;
            cnt       <= '0;
            iter_done <= 1'b0;
            req_rdy   <= 1'b1;
            resp_val  <= 1'b0;
        end else begin
            case (state)
                MULDIV_ST_IDLE: begin
                    if (req_val) begin
                        state     <= MULDIV_ST_CALC;
                        cnt       <= 5'd31;
                        iter_done <= 1'b0;
                        req_rdy   <= 1'b0;
                    end
                end
                MULDIV_ST_CALC: begin
                    if (calc_exit) begin
                        state <= MULDIV_ST_FIX;
                    end else if (cnt == 5'd0) begin
                        iter_done <= 1'b1;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                MULDIV_ST_FIX: begin
                    state    <= MULDIV_ST_DONE;
                    resp_val <= 1'b1;
                end
                MULDIV_ST_DONE: begin
                    if (resp_rdy) begin
                        state    <= MULDIV_ST_IDLE;
                        resp_val <= 1'b0;
                        req_rdy  <= 1'b1;
                    end
                end
                default: begin
                    state    <= MULDIV_ST_IDLE;
                    req_rdy  <= 1'b1;
                    resp_val <= 1'b0;
                end
            endcase
        end
    end

    mcparc_core_muldiv_iter_dpath u_dpath (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .fn         (req_fn),
        .a          (req_a),
        .b          (req_b),
        .step       (step),
        .fix        (fix),
        .early_done (early_done),
        .result     (resp_result)
    );

endmodule

// File: tb/tb_mcparc_core_muldiv_iter.sv
// Self-checking bench for mcparc_core_muldiv_iter: directed vector table, corner sequences, random ops vs a model.
// Expected latency follows MCPARC_MULDIV_EARLY_EXIT_EN when the bench is built with it.
module tb_mcparc_core_muldiv_iter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_val;
    logic        req_rdy;
    logic [2:0]  req_fn;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_val;
    logic        resp_rdy;
    logic [31:0] resp_result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mcparc_core_muldiv_iter #(.NBITS(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_val     (req_val),
        .req_rdy     (req_rdy),
        .req_fn      (req_fn),
        .req_a       (req_a),
        .req_b       (req_b),
        .resp_val    (resp_val),
        .resp_rdy    (resp_rdy),
        .resp_result (resp_result)
    );

    typedef struct {
        string       name;
        logic [2:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference semantics from plain integer arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [63:0]        prod;
        sa = a;
        sb = b;
        case (fn)
            3'd0: begin
                prod = {32'd0, a} * {32'd0, b};
                return prod[31:0];
            end
            3'd1: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            3'd2: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd3: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb;
            end
            3'd4: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] fn, input logic [31:0] b);
        int msb;
        msb = -1;
`ifdef MCPARC_MULDIV_EARLY_EXIT_EN
        if (fn == 3'd0) begin
            for (int i = 0; i < 32; i++) if (b[i]) msb = i;
            return (msb < 0) ? 2 : msb + 3;
        end
`endif
        return 34 + msb - msb;
    endfunction

    task automatic issue(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
        int g;
        g = 0;
        while (!req_rdy && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        check("req_rdy before issue", {31'd0, req_rdy}, 32'd1);
        req_val = 1'b1;
        req_fn  = fn;
        req_a   = a;
        req_b   = b;
        @(posedge clk); #1;
        req_val = 1'b0;
        req_fn  = 3'($urandom);
        req_a   = $urandom;
        req_b   = $urandom;
    endtask

    task automatic await_resp(output logic [31:0] res, output int lat);
        lat = 0;
        while (!resp_val && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = resp_result;
    endtask

    task automatic handshake();
        resp_rdy = 1'b1;
        @(posedge clk); #1;
        resp_rdy = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [2:0] fn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        logic [31:0] res;
        int          lat;
        issue(fn, a, b);
        await_resp(res, lat);
        check(name, res, exp);
        check({name, " latency"}, lat, exp_lat(fn, b));
        handshake();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] res;
        int          lat;
        bit          seen;
        logic [2:0]  fn;
        logic [31:0] a;
        logic [31:0] b;

        vecs[0]  = '{"MUL 7x6",            3'd0, 32'd7,         32'd6,         32'd42};
        vecs[1]  = '{"MUL -1x-1",          3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1};
        vecs[2]  = '{"DIV -7/2",           3'd1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
        vecs[3]  = '{"REM -7/2",           3'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
        vecs[4]  = '{"DIVU big/2",         3'd2, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC};
        vecs[5]  = '{"REMU big/2",         3'd4, 32'hFFFF_FFF9, 32'd2,         32'd1};
        vecs[6]  = '{"DIV overflow",       3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[7]  = '{"REM overflow",       3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
        vecs[8]  = '{"DIV 5/0",            3'd1, 32'd5,         32'd0,         32'hFFFF_FFFF};
        vecs[9]  = '{"REM 5/0",            3'd3, 32'd5,         32'd0,         32'd5};
        vecs[10] = '{"REMU big/0",         3'd4, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB};
        vecs[11] = '{"DIV -5/0",           3'd1, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF};
        vecs[12] = '{"REM -5/0",           3'd3, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB};
        vecs[13] = '{"DIVU 5/0",           3'd2, 32'd5,         32'd0,         32'hFFFF_FFFF};
        vecs[14] = '{"reserved fn 6",      3'd6, 32'd123,       32'd45,        32'd0};
        vecs[15] = '{"DIV 100/-7",         3'd1, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2};

        reset    = 1'b0;
        req_val  = 1'b0;
        resp_rdy = 1'b0;
        req_fn   = '0;
        req_a    = '0;
        req_b    = '0;
        #2 reset = 1'b1;
        #1;
        check("reset req_rdy", {31'd0, req_rdy}, 32'd1);
        check("reset resp_val", {31'd0, resp_val}, 32'd0);
        check("reset resp_result", resp_result, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].name, vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // Backpressure: result held while resp_rdy low; a pending request waits for the handshake.
        issue(3'd2, 32'd100, 32'd7);
        await_resp(res, lat);
        check("bp result", res, 32'd14);
        req_val = 1'b1;
        req_fn  = 3'd0;
        req_a   = 32'd3;
        req_b   = 32'd5;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp hold resp_val", {31'd0, resp_val}, 32'd1);
            check("bp hold result", resp_result, 32'd14);
            check("bp hold req_rdy", {31'd0, req_rdy}, 32'd0);
        end
        resp_rdy = 1'b1;
        @(posedge clk); #1;
        resp_rdy = 1'b0;
        check("bp after handshake resp_val", {31'd0, resp_val}, 32'd0);
        check("bp after handshake req_rdy", {31'd0, req_rdy}, 32'd1);
        @(posedge clk); #1;
        check("bp accepted next cycle", {31'd0, req_rdy}, 32'd0);
        req_val = 1'b0;
        await_resp(res, lat);
        check("bp second op", res, 32'd15);
        check("bp second op latency", lat, exp_lat(3'd0, 32'd5));
        handshake();

        // Asynchronous reset part-way through CALC.
        issue(3'd1, 32'd100, 32'd7);
        repeat (14) begin
            @(posedge clk); #1;
        end
        #3 reset = 1'b1;
        #1;
        check("async reset resp_val", {31'd0, resp_val}, 32'd0);
        check("async reset req_rdy", {31'd0, req_rdy}, 32'd1);
        check("async reset resp_result", resp_result, 32'd0);
        @(negedge clk) reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (resp_val) seen = 1'b1;
        end
        check("no response from discarded op", {31'd0, seen}, 32'd0);
        run_op("DIV 9/3 after reset", 3'd1, 32'd9, 32'd3, 32'd3);

        for (int n = 0; n < 1000; n++) begin
            fn = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFF_FFFF;
                3:       b = 32'd1 << $urandom_range(0, 31);
                4:       b = -($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       a = 32'h8000_0000;
                1:       a = $urandom_range(0, 1000);
                2:       a = -($urandom_range(0, 1000));
                default: a = $urandom;
            endcase
            issue(fn, a, b);
            await_resp(res, lat);
            check("random result", res, ref_result(fn, a, b));
            check("random latency", lat, exp_lat(fn, b));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 4)) begin
                    @(posedge clk); #1;
                end
                check("random hold result", resp_result, ref_result(fn, a, b));
            end
            handshake();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
